// File: rtl/arbiter_request_controller.sv
// Per-device bus front end: takes a burst command, requests the shared bus, streams the beats, then releases.
// Optional grant-wait timeout is enabled by defining REQUEST_TIMEOUT_EN.
module arbiter_request_controller #(
  parameter int DATA_WIDTH     = 32,
  parameter int LENGTH_WIDTH   = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [LENGTH_WIDTH-1:0] cmd_length,
  output logic                    cmd_done,
  output logic                    cmd_error,
  input  logic                    wr_valid,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    wr_ready,
  output logic                    request,
  input  logic                    grant,
  output logic                    bus_valid,
  output logic [DATA_WIDTH-1:0]   bus_data,
  output logic                    bus_last,
  input  logic                    bus_ready
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] REQUEST  = 2'd1;
  localparam logic [1:0] TRANSFER = 2'd2;
  localparam logic [1:0] RELEASE  = 2'd3;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0]              state;
  logic [LENGTH_WIDTH-1:0] count;
  logic [LENGTH_WIDTH-1:0] length;
  logic                    handshake;

  assign cmd_ready = (state == IDLE);
  assign bus_valid = (state == TRANSFER) && grant && wr_valid;
  assign wr_ready  = bus_valid && bus_ready;
  assign handshake = wr_ready;
  assign bus_data  = wr_data;
  assign bus_last  = bus_valid && (count == length - 1'b1);

`ifdef REQUEST_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] wait_count;
  logic          timed_out;
  logic          error_q;

  assign cmd_error = error_q;
`else
  assign cmd_error = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      request  <= 1'b0;
      cmd_done <= 1'b0;
      count    <= '0;
      length   <= '0;
`ifdef REQUEST_TIMEOUT_EN
      wait_count <= '0;
      timed_out  <= 1'b0;
      error_q    <= 1'b0;
`endif
    end else begin
      cmd_done <= 1'b0;
`ifdef REQUEST_TIMEOUT_EN
      error_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            length <= cmd_length;
            count  <= '0;
`ifdef REQUEST_TIMEOUT_EN
            wait_count <= '0;
            timed_out  <= 1'b0;
`endif
            // A zero-length burst completes without ever touching the arbiter
            if (cmd_length == '0) begin
              cmd_done <= 1'b1;
            end else begin
              state   <= REQUEST;
              request <= 1'b1;
            end
          end
        end
        REQUEST: begin
          if (grant) begin
            state <= TRANSFER;
          end
`ifdef REQUEST_TIMEOUT_EN
          else if (wait_count == TW'(TIMEOUT_CYCLES - 1)) begin
            request   <= 1'b0;
            state     <= RELEASE;
            timed_out <= 1'b1;
          end else begin
            wait_count <= wait_count + 1'b1;
          end
`endif
        end
        TRANSFER: begin
          if (handshake) begin
            if (bus_last) begin
              state   <= RELEASE;
              request <= 1'b0;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        RELEASE: begin
          // Hold off until the arbiter has let go, so a lingering grant is never reused
          if (!grant) begin
            cmd_done <= 1'b1;
            state    <= IDLE;
`ifdef REQUEST_TIMEOUT_EN
            error_q <= timed_out;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arbiter_request_controller.sv
// Self-checking bench for arbiter_request_controller: transaction-level model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_arbiter_request_controller;

  localparam int DW = 32;
  localparam int LW = 8;
`ifdef REQUEST_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 256;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [LW-1:0] cmd_length = '0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          grant = 1'b0;
  logic          bus_ready = 1'b0;
  logic          cmd_ready, cmd_done, cmd_error, wr_ready, request;
  logic          bus_valid, bus_last;
  logic [DW-1:0] bus_data;

  arbiter_request_controller #(
    .DATA_WIDTH    (DW),
    .LENGTH_WIDTH  (LW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_length(cmd_length),
    .cmd_done  (cmd_done),
    .cmd_error (cmd_error),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .request   (request),
    .grant     (grant),
    .bus_valid (bus_valid),
    .bus_data  (bus_data),
    .bus_last  (bus_last),
    .bus_ready (bus_ready)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Transaction-level model: outstanding burst, beats remaining, whether we hold the bus
  bit armed = 0;
  bit m_busy = 0, m_req = 0, m_xfer = 0, m_done = 0, m_err = 0, m_abort = 0;
  int m_left = 0;
`ifdef REQUEST_TIMEOUT_EN
  int m_wait = 0;
`endif

  // Observed-event statistics for the directed literal checks
  int cyc = 0, n_acc = 0, n_rise = 0, n_beats = 0, n_last = 0, n_done = 0, n_err = 0, n_valid = 0;
  int t_acc = -1, t_rise = -1, t_fall = -1, t_first = -1, t_last = -1, t_done = -1;
  int rise_q[$], done_q[$];
  logic [DW-1:0] got[$];
  logic prev_req = 1'b0;

  always @(negedge clock) begin
    bit e_valid, e_last, done_n, err_n;
    #2;
    e_valid = m_xfer && grant && wr_valid;
    e_last  = e_valid && (m_left == 1);
    if (armed) begin
      chk("cmd_ready", cmd_ready, !m_busy);
      chk("request",   request,   m_req);
      chk("bus_valid", bus_valid, e_valid);
      chk("bus_last",  bus_last,  e_last);
      chk("wr_ready",  wr_ready,  e_valid && bus_ready);
      chk("cmd_done",  cmd_done,  m_done);
      chk("cmd_error", cmd_error, m_err);
      if (e_valid) chk("bus_data", bus_data, wr_data);
    end

    cyc++;
    if (cmd_valid && cmd_ready) begin n_acc++; t_acc = cyc; end
    if (request && !prev_req) begin n_rise++; t_rise = cyc; rise_q.push_back(cyc); end
    if (!request && prev_req) t_fall = cyc;
    prev_req = request;
    if (bus_valid) n_valid++;
    if (bus_valid && bus_ready) begin
      if (n_beats == 0) t_first = cyc;
      n_beats++;
      got.push_back(bus_data);
      if (bus_last) begin n_last++; t_last = cyc; end
    end
    if (cmd_done) begin n_done++; t_done = cyc; done_q.push_back(cyc); if (cmd_error) n_err++; end

    done_n = 0;
    err_n  = 0;
    if (reset) begin
      m_busy = 0; m_req = 0; m_xfer = 0; m_left = 0; m_abort = 0;
      armed = 1;
    end else if (!m_busy) begin
      if (cmd_valid) begin
        if (cmd_length == 0) done_n = 1;
        else begin
          m_busy = 1; m_req = 1; m_left = int'(cmd_length); m_abort = 0;
`ifdef REQUEST_TIMEOUT_EN
          m_wait = 0;
`endif
        end
      end
    end else if (m_xfer) begin
      if (e_valid && bus_ready) begin
        m_left--;
        if (m_left == 0) begin m_xfer = 0; m_req = 0; end
      end
    end else if (m_req) begin
      if (grant) m_xfer = 1;
`ifdef REQUEST_TIMEOUT_EN
      else begin
        m_wait++;
        if (m_wait == TO) begin m_req = 0; m_abort = 1; end
      end
`endif
    end else if (!grant) begin
      m_busy = 0; done_n = 1; err_n = m_abort;
    end
    m_done = done_n;
    m_err  = err_n;
  end

  // Stimulus side: arbiter behaviour and client data sequencing
  bit random_arb = 0;
  int grant_delay = 2, hold = 1, req_cnt = 0, low_cnt = 0;
  int data_idx = 0;
  logic [DW-1:0] data_base = '0;

  task automatic step();
    #1;
    if (wr_valid && wr_ready) data_idx++;
    @(negedge clock);
    if (random_arb) grant = request ? ($urandom % 4 != 0) : ($urandom % 3 == 0);
    else if (request) begin
      low_cnt = 0; req_cnt++; grant = (req_cnt > grant_delay);
    end else begin
      req_cnt = 0;
      if (grant) begin
        low_cnt++;
        if (low_cnt > hold) begin grant = 0; low_cnt = 0; end
      end
    end
    wr_data = data_base + DW'(data_idx);
  endtask

  task automatic clear_stats();
    n_acc = 0; n_rise = 0; n_beats = 0; n_last = 0; n_done = 0; n_err = 0; n_valid = 0;
    t_acc = -1; t_rise = -1; t_fall = -1; t_first = -1; t_last = -1; t_done = -1;
    rise_q.delete(); done_q.delete(); got.delete();
  endtask

  task automatic wait_done(input int n, input int budget, input string name);
    int k = 0;
    while (n_done < n && k < budget) begin step(); k++; end
    chk(name, n_done, n);
  endtask

  initial begin
    int k;
    reset = 1;
    repeat (3) step();
    reset = 0;
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_request",   request,   0);
    chk("rst_cmd_done",  cmd_done,  0);
    chk("rst_bus_valid", bus_valid, 0);
    chk("rst_cmd_error", cmd_error, 0);

    // Single 4-beat burst, grant two cycles after request
    clear_stats();
    data_base = 32'h100; data_idx = 0; wr_valid = 1; bus_ready = 1;
    cmd_valid = 1; cmd_length = 4;
    step();
    cmd_valid = 0; cmd_length = 0;
    wait_done(1, 40, "b4_done");
    chk("b4_beats",     n_beats, 4);
    chk("b4_last",      n_last, 1);
    chk("b4_error",     n_err, 0);
    chk("b4_req_lat",   t_rise - t_acc, 1);
    chk("b4_grant_lat", t_first - t_rise, 3);
    chk("b4_consec",    t_last - t_first, 3);
    chk("b4_req_fall",  t_fall - t_last, 1);
    chk("b4_done_lat",  t_done - t_fall, 2);
    repeat (2) step();

    // Backpressure: bus_ready alternates, data order must survive
    clear_stats();
    data_base = 32'hA1; data_idx = 0;
    cmd_valid = 1; cmd_length = 3;
    step();
    cmd_valid = 0;
    k = 0;
    while (n_done < 1 && k < 60) begin bus_ready = (k % 2 == 0); step(); k++; end
    chk("bp_done",  n_done, 1);
    chk("bp_beats", n_beats, 3);
    for (int i = 0; i < 3; i++)
      chk("bp_data", (i < got.size()) ? got[i] : '1, 64'hA1 + 64'(i));
    bus_ready = 1;
    repeat (2) step();

    // Zero-length command
    clear_stats();
    cmd_valid = 1; cmd_length = 0;
    step();
    cmd_valid = 0;
    repeat (3) step();
    chk("zl_done",  n_done, 1);
    chk("zl_rise",  n_rise, 0);
    chk("zl_lat",   t_done - t_acc, 1);

    // Back-to-back with grant held an extra cycle
    clear_stats();
    hold = 2; data_base = 32'h300; data_idx = 0;
    cmd_valid = 1; cmd_length = 2;
    k = 0;
    while (n_acc < 2 && k < 60) begin step(); k++; end
    cmd_valid = 0;
    wait_done(2, 60, "b2b_done");
    chk("b2b_beats", n_beats, 4);
    chk("b2b_rises", rise_q.size(), 2);
    if (rise_q.size() == 2 && done_q.size() >= 1)
      chk("b2b_order", rise_q[1] > done_q[0], 1);
    hold = 1;
    repeat (3) step();

    // Reset in the middle of a 5-beat burst
    clear_stats();
    data_base = 32'h500; data_idx = 0;
    cmd_valid = 1; cmd_length = 5;
    step();
    cmd_valid = 0;
    k = 0;
    while (n_beats < 2 && k < 40) begin step(); k++; end
    chk("mr_two_beats", n_beats, 2);
    reset = 1;
    step();
    reset = 0;
    #1;
    chk("mr_request",   request, 0);
    chk("mr_cmd_ready", cmd_ready, 1);
    repeat (4) step();
    chk("mr_no_done", n_done, 0);
    clear_stats();
    cmd_valid = 1; cmd_length = 1;
    step();
    cmd_valid = 0;
    wait_done(1, 40, "mr_fresh_done");
    chk("mr_fresh_beats", n_beats, 1);
    chk("mr_fresh_err",   n_err, 0);
    repeat (3) step();

`ifdef REQUEST_TIMEOUT_EN
    // Grant never arrives: abort after TO cycles in REQUEST
    clear_stats();
    grant_delay = 1000;
    cmd_valid = 1; cmd_length = 2;
    step();
    cmd_valid = 0;
    wait_done(1, 60, "to_done");
    chk("to_error",   n_err, 1);
    chk("to_valid",   n_valid, 0);
    chk("to_req_len", t_fall - t_rise, 8);
    grant_delay = 2;
    repeat (3) step();
`endif

    // Randomized traffic against the model
    random_arb = 1;
    for (int i = 0; i < 3000; i++) begin
      step();
      reset      = ($urandom % 500 == 0);
      cmd_valid  = ($urandom % 3 == 0);
      cmd_length = LW'($urandom % 6);
      wr_valid   = ($urandom % 4 != 0);
      bus_ready  = ($urandom % 4 != 0);
      wr_data    = $urandom;
    end
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/arbiter_request_controller.md
Name: arbiter_request_controller

Overview:
- Per-device front end that sits directly upstream of the shared-bus arbiter, one instance per device.
- Accepts a burst command from the device's client logic and raises `request` toward the arbiter.
- Once granted, streams exactly the commanded number of beats onto the shared bus, then drops `request`.
- Waits until the arbiter has withdrawn `grant` before accepting the next command, so a held grant is never mistaken for a new one.

Parameters:
- DATA_WIDTH, 32, width of bus/client data beats.
- LENGTH_WIDTH, 8, width of burst length field (max burst = 2^LENGTH_WIDTH - 1 beats).
- TIMEOUT_CYCLES, 256, grant-wait limit in cycles; used only when REQUEST_TIMEOUT_EN is defined.

Ports:
- clock  input  1  single clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  client presents a burst command.
- cmd_ready  output  1  controller can accept a command (IDLE only).
- cmd_length  input  LENGTH_WIDTH  beats in burst; sampled on cmd_valid && cmd_ready.
- cmd_done  output  1  one-cycle pulse when the burst finishes or is aborted.
- cmd_error  output  1  qualifies cmd_done: 1 = aborted by timeout.
- wr_valid  input  1  client data beat valid.
- wr_data  input  DATA_WIDTH  client data beat.
- wr_ready  output  1  client beat consumed this cycle.
- request  output  1  to arbiter; registered.
- grant  input  1  from arbiter.
- bus_valid  output  1  beat on shared bus.
- bus_data  output  DATA_WIDTH  beat data (wr_data passthrough).
- bus_last  output  1  final beat of the burst.
- bus_ready  input  1  bus target accepts the beat.

Behaviour:
- Reset (synchronous, active-high): on the first rising edge with reset=1:
  - state=IDLE; request=0; cmd_done=0; cmd_error=0; beat counter=0; stored length=0; timeout counter=0.
  - Reset mid-burst abandons the burst silently: no cmd_done pulse, request low after that edge.
- Combinational outputs:
  - cmd_ready = (state==IDLE).
  - bus_valid = (state==TRANSFER) && grant && wr_valid.
  - wr_ready = bus_valid && bus_ready.
  - bus_data = wr_data.
  - bus_last = bus_valid && (count == length-1).
- Beat handshake: a beat transfers when bus_valid && bus_ready. The count increments by 1, modulo-free; count never exceeds length-1.
- IDLE:
  - On cmd_valid && cmd_ready, latch cmd_length.
  - If length==0: next cycle cmd_done=1 and stay IDLE. request is never raised.
  - Else: state REQUEST; request=1 from the next cycle.
- REQUEST:
  - request held 1.
  - On grant==1: state TRANSFER.
  - Beats cannot issue in the grant-arrival cycle, because bus_valid requires state TRANSFER. This costs one cycle of latency.
- TRANSFER:
  - request held 1.
  - If grant drops unexpectedly, bus_valid is gated low and the controller stalls until grant returns. No error is raised.
  - On the handshake where bus_last=1: state RELEASE; request=0 after that edge.
- RELEASE:
  - request=0.
  - Wait while grant==1. The arbiter drops grant one cycle after it sees request low.
  - When grant==0: cmd_done pulses 1 for one cycle (cmd_error=0) and the state returns to IDLE.
  - A new command is accepted no earlier than the cycle after cmd_done.
- Latency, best case, for an N-beat burst:
  - cmd accept to request high: 1 cycle.
  - grant to first beat: 1 cycle.
  - last beat to request low: 1 cycle.
  - cmd_done: 1 cycle after grant is observed low.
- Simultaneous events:
  - cmd_valid is ignored outside IDLE.
  - grant arriving in the same cycle request first rises is impossible, since request is registered. Any grant seen in IDLE is ignored.
  - wr_valid without grant produces no beat.

Optional Feature:
- Macro: REQUEST_TIMEOUT_EN.
- With the macro defined:
  - In REQUEST, a counter increments each cycle grant==0 and clears on entry to REQUEST.
  - When it reaches TIMEOUT_CYCLES-1 without grant: request=0, state RELEASE.
  - On leaving RELEASE, cmd_done=1 with cmd_error=1.
  - Timeout is not checked in TRANSFER.
- Without the macro: no counter is instantiated, REQUEST waits indefinitely, and cmd_error is tied 0.

Test Plan:
- Single burst: cmd_length=4, grant rises 2 cycles after request, bus_ready=1, wr_valid=1 -> 4 beats on consecutive cycles, bus_last on 4th only, request low the cycle after, cmd_done one cycle after grant falls, cmd_error=0.
- Backpressure: cmd_length=3, bus_ready toggled 1,0,1,0,1 -> exactly 3 beats transferred, wr_ready only on accepted beats, data order preserved (e.g. 0xA1, 0xA2, 0xA3).
- Zero length: cmd_length=0 -> request never rises, cmd_done=1 one cycle after accept, cmd_ready stays 1 that cycle.
- Back-to-back: two commands of length 2, grant held one extra cycle after request drops -> second request not raised until after grant=0 and cmd_done seen; no beat issued without grant.
- Reset mid-burst: reset=1 after 2 of 5 beats -> next edge request=0, state IDLE, no cmd_done; a fresh cmd_length=1 then completes normally.
- Timeout (REQUEST_TIMEOUT_EN, TIMEOUT_CYCLES=8): grant held 0 -> request drops after 8 cycles in REQUEST, cmd_done=1 with cmd_error=1, no bus_valid ever asserted.
